// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: parametrised 2R/1W register file with clearing sweep
// and a per-register pending scoreboard for RAW hazard detection.
module regfile_mp_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 6,
   parameter int NUM_REGS = 64,
   parameter int ZERO_REG = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_ctrl_regwrt,
   input  logic [ADDR_W-1:0] in_rd,
   input  logic [DATA_W-1:0] in_rdval,
   input  logic [ADDR_W-1:0] in_rs,
   input  logic [ADDR_W-1:0] in_rt,
   input  logic              in_ctrl_claim,
   input  logic [ADDR_W-1:0] in_claim_rd,
   output logic [DATA_W-1:0] out_rsval,
   output logic [DATA_W-1:0] out_rtval,
   output logic              out_rs_pending,
   output logic              out_rt_pending,
   output logic              out_busy
);

   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_REGS);

   typedef enum logic {
      INIT,
      RUN
   } state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   cnt_q;
   logic [DATA_W-1:0]   mem_q [NUM_REGS];
   logic [NUM_REGS-1:0] pend_q;
   logic [NUM_REGS-1:0] pend_d;
   logic [DATA_W-1:0]   rsval_q, rsval_d;
   logic [DATA_W-1:0]   rtval_q, rtval_d;
   logic                rsp_q, rsp_d;
   logic                rtp_q, rtp_d;
   logic                busy_q;
   logic                wr_ok;
   logic                cl_ok;

   // address lies inside the implemented register range
   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return {1'b0, a} < LIMIT;
   endfunction

   // address names a real, writable register (zero reg excluded)
   function automatic logic live(input logic [ADDR_W-1:0] a);
      return in_range(a) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
      return IDX_W'(a);
   endfunction

   assign wr_ok = in_ctrl_regwrt && live(in_rd);
   assign cl_ok = in_ctrl_claim && live(in_claim_rd);

   // scoreboard next state: write clears, a same-cycle claim wins
   always_comb begin
      pend_d = pend_q;
      if (wr_ok) begin
         pend_d[idx(in_rd)] = 1'b0;
      end
      if (cl_ok) begin
         pend_d[idx(in_claim_rd)] = 1'b1;
      end
   end

   // write-first read ports and post-update pending lookup
   always_comb begin
      rsval_d = '0;
      rtval_d = '0;
      rsp_d   = 1'b0;
      rtp_d   = 1'b0;
      if (live(in_rs)) begin
         if (wr_ok && (in_rd == in_rs)) begin
            rsval_d = in_rdval;
         end else begin
            rsval_d = mem_q[idx(in_rs)];
         end
      end
      if (live(in_rt)) begin
         if (wr_ok && (in_rd == in_rt)) begin
            rtval_d = in_rdval;
         end else begin
            rtval_d = mem_q[idx(in_rt)];
         end
      end
      if (in_range(in_rs)) begin
         rsp_d = pend_d[idx(in_rs)];
      end
      if (in_range(in_rt)) begin
         rtp_d = pend_d[idx(in_rt)];
      end
   end

   // storage array: sweep clears one entry per edge, then writeback
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == INIT) begin
            mem_q[idx(cnt_q)] <= '0;
         end else if (wr_ok) begin
            mem_q[idx(in_rd)] <= in_rdval;
         end
      end
   end

   // control FSM with registered read, pending and busy outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= INIT;
         cnt_q   <= '0;
         pend_q  <= '0;
         busy_q  <= 1'b1;
         rsval_q <= '0;
         rtval_q <= '0;
         rsp_q   <= 1'b0;
         rtp_q   <= 1'b0;
      end else begin
         unique case (state_q)
            INIT: begin
               cnt_q   <= cnt_q + 1'b1;
               rsval_q <= '0;
               rtval_q <= '0;
               rsp_q   <= 1'b0;
               rtp_q   <= 1'b0;
               if (cnt_q == LAST) begin
                  state_q <= RUN;
                  busy_q  <= 1'b0;
               end
            end
            RUN: begin
               pend_q  <= pend_d;
               rsval_q <= rsval_d;
               rtval_q <= rtval_d;
               rsp_q   <= rsp_d;
               rtp_q   <= rtp_d;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= INIT;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign out_rsval      = rsval_q;
   assign out_rtval      = rtval_q;
   assign out_rs_pending = rsp_q;
   assign out_rt_pending = rtp_q;
   assign out_busy       = busy_q;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: random + directed check of two regfile configs
// against an array-based reference model.
module tb_regfile_mp_sb;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [5:0]  rd;
   logic [31:0] val;
   logic [5:0]  rs;
   logic [5:0]  rt;
   logic        cl;
   logic [5:0]  crd;

   logic [31:0] rsA, rtA, rsB, rtB;
   logic        rspA, rtpA, busyA;
   logic        rspB, rtpB, busyB;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   regfile_mp_sb dut (
      .clk(clk), .rst(rst),
      .in_ctrl_regwrt(we), .in_rd(rd), .in_rdval(val),
      .in_rs(rs), .in_rt(rt),
      .in_ctrl_claim(cl), .in_claim_rd(crd),
      .out_rsval(rsA), .out_rtval(rtA),
      .out_rs_pending(rspA), .out_rt_pending(rtpA),
      .out_busy(busyA)
   );

   regfile_mp_sb #(.NUM_REGS(32), .ZERO_REG(1)) dutz (
      .clk(clk), .rst(rst),
      .in_ctrl_regwrt(we), .in_rd(rd), .in_rdval(val),
      .in_rs(rs), .in_rt(rt),
      .in_ctrl_claim(cl), .in_claim_rd(crd),
      .out_rsval(rsB), .out_rtval(rtB),
      .out_rs_pending(rspB), .out_rt_pending(rtpB),
      .out_busy(busyB)
   );

   int          N [2] = '{64, 32};
   bit          Z [2] = '{1'b0, 1'b1};
   logic [31:0] mm [2][64];
   bit          pp [2][64];
   int          left [2];
   logic [31:0] ers [2];
   logic [31:0] ert [2];
   bit          eps [2];
   bit          ept [2];
   bit          ebusy [2];

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic bit live(input int k, input int a);
      return (a < N[k]) && !(Z[k] && a == 0);
   endfunction

   task automatic mstep(input int k);
      if (rst) begin
         left[k] = N[k];
         for (int i = 0; i < 64; i++) pp[k][i] = 0;
         ers[k] = 0; ert[k] = 0; eps[k] = 0; ept[k] = 0;
         ebusy[k] = 1;
      end else if (left[k] > 0) begin
         mm[k][N[k] - left[k]] = 0;
         left[k]--;
         ebusy[k] = (left[k] > 0);
         ers[k] = 0; ert[k] = 0; eps[k] = 0; ept[k] = 0;
      end else begin
         if (we && live(k, rd)) begin
            mm[k][rd] = val;
            pp[k][rd] = 0;
         end
         if (cl && live(k, crd)) pp[k][crd] = 1;
         ers[k] = live(k, rs) ? mm[k][rs] : 32'd0;
         ert[k] = live(k, rt) ? mm[k][rt] : 32'd0;
         eps[k] = (rs < N[k]) ? pp[k][rs] : 1'b0;
         ept[k] = (rt < N[k]) ? pp[k][rt] : 1'b0;
         ebusy[k] = 0;
      end
   endtask

   task automatic cyc(input bit r, input bit w,
                      input logic [5:0] a_rd, input logic [31:0] v,
                      input logic [5:0] a_rs, input logic [5:0] a_rt,
                      input bit c, input logic [5:0] a_crd);
      rst = r; we = w; rd = a_rd; val = v;
      rs = a_rs; rt = a_rt; cl = c; crd = a_crd;
      @(posedge clk);
      mstep(0);
      mstep(1);
      #1;
      chk("a_rsval", rsA, ers[0]);
      chk("a_rtval", rtA, ert[0]);
      chk("a_rspend", {31'd0, rspA}, {31'd0, eps[0]});
      chk("a_rtpend", {31'd0, rtpA}, {31'd0, ept[0]});
      chk("a_busy", {31'd0, busyA}, {31'd0, ebusy[0]});
      chk("z_rsval", rsB, ers[1]);
      chk("z_rtval", rtB, ert[1]);
      chk("z_rspend", {31'd0, rspB}, {31'd0, eps[1]});
      chk("z_rtpend", {31'd0, rtpB}, {31'd0, ept[1]});
      chk("z_busy", {31'd0, busyB}, {31'd0, ebusy[1]});
   endtask

   task automatic idle(input logic [5:0] a, input logic [5:0] b);
      cyc(0, 0, 0, 0, a, b, 0, 0);
   endtask

   initial begin
      int first_a;
      int first_b;
      rst = 1; we = 0; rd = 0; val = 0;
      rs = 0; rt = 0; cl = 0; crd = 0;
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 64; i++) begin
            mm[k][i] = 0;
            pp[k][i] = 0;
         end

      // reset held two cycles, then sweep with junk writes/claims
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 5, 32'h55, 5, 5, 1, 5);
      first_a = 0;
      first_b = 0;
      for (int i = 1; i <= 64; i++) begin
         cyc(0, 1, 6'($urandom_range(0, 63)), $urandom,
             6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
             1, 6'($urandom_range(0, 63)));
         if (!busyA && first_a == 0) first_a = i;
         if (!busyB && first_b == 0) first_b = i;
      end
      chk("busy_len_a", first_a, 64);
      chk("busy_len_z", first_b, 32);

      for (int i = 0; i < 64; i++) begin
         idle(6'(i), 6'(63 - i));
         chk("swp_val", rsA, 0);
         chk("swp_pend", {31'd0, rspA}, 0);
      end

      // write then read
      cyc(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
      idle(5, 6);
      chk("wr_rd5", rsA, 32'hDEADBEEF);
      chk("wr_rd6", rtA, 0);

      // same-cycle bypass on both ports
      cyc(0, 1, 9, 32'h1234, 9, 9, 0, 0);
      chk("byp_rs", rsA, 32'h1234);
      chk("byp_rt", rtA, 32'h1234);
      cyc(0, 1, 10, 32'h5678, 9, 10, 0, 0);
      chk("byp_old9", rsA, 32'h1234);

      // scoreboard
      cyc(0, 0, 0, 0, 3, 3, 1, 3);
      chk("sb_claim", {31'd0, rspA}, 1);
      cyc(0, 1, 3, 7, 3, 3, 0, 0);
      chk("sb_clr", {31'd0, rspA}, 0);
      chk("sb_val", rsA, 7);
      cyc(0, 1, 3, 8, 3, 3, 1, 3);
      chk("sb_both_p", {31'd0, rspA}, 1);
      chk("sb_both_v", rsA, 8);

      // zero register and out-of-range on the 32-entry instance
      cyc(0, 1, 0, 32'hFF, 0, 0, 1, 0);
      chk("z0_val", rsB, 0);
      chk("z0_pend", {31'd0, rspB}, 0);
      cyc(0, 1, 40, 32'hABCD, 40, 40, 1, 40);
      chk("z40_val", rsB, 0);
      chk("z40_pend", {31'd0, rspB}, 0);

      // mid-run reset wipes data and pending state
      for (int i = 1; i <= 4; i++)
         cyc(0, 1, 6'(i), 32'hA0 + i, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 2, 2, 1, 2);
      chk("mid_pend", {31'd0, rspA}, 1);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 64; i++) idle(0, 0);
      chk("mid_busy", {31'd0, busyA}, 0);
      for (int i = 1; i <= 4; i++) begin
         idle(6'(i), 2);
         chk("mid_val", rsA, 0);
         chk("mid_p2", {31'd0, rtpA}, 0);
      end

      // randomized traffic with occasional resets
      for (int n = 0; n < 3000; n++) begin
         logic [5:0] a1, a2, a3, a4;
         a1 = 6'($urandom_range(0, 63));
         a2 = ($urandom_range(0, 3) == 0) ? a1 : 6'($urandom_range(0, 63));
         a3 = ($urandom_range(0, 3) == 0) ? a1 : 6'($urandom_range(0, 63));
         a4 = ($urandom_range(0, 3) == 0) ? a2 : 6'($urandom_range(0, 63));
         cyc(($urandom_range(0, 399) == 0), $urandom_range(0, 1) == 1,
             a1, $urandom, a2, a3, $urandom_range(0, 2) == 0, a4);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
